// File: rtl/arbitro_pkg.sv
// Shared sizing and helpers for the round-robin FIFO drain arbiter.
package arbitro_pkg;

    localparam int FIFO_UNITS = 4;
    localparam int INDEX      = 2;
    localparam int DATA_WIDTH = 6;
    localparam int PTR_W      = INDEX;

    // The destination index sits in the top INDEX bits of every FIFO word.
    function automatic logic [INDEX-1:0] dest_of(input logic [DATA_WIDTH-1:0] word);
        return word[DATA_WIDTH-1 -: INDEX];
    endfunction

endpackage

// File: rtl/arbitro_rr_sel.sv
// Round-robin search: rotate the eligible vector by rr_ptr, take the lowest set bit,
// then rotate the result back into absolute FIFO numbering.
module arbitro_rr_sel
    import arbitro_pkg::*;
(
    input  logic [FIFO_UNITS-1:0] eligible,
    input  logic [PTR_W-1:0]      rr_ptr,
    output logic [FIFO_UNITS-1:0] gnt_onehot,
    output logic [INDEX-1:0]      gnt_idx,
    output logic                  gnt_valid
);

    logic [FIFO_UNITS-1:0] rot_s;
    logic [INDEX-1:0]      enc_s;
    logic                  found_s;

    // rotate, priority-encode, unrotate
    always_comb begin
        rot_s   = {FIFO_UNITS{1'b0}};
        enc_s   = {INDEX{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < FIFO_UNITS; i++) begin
            rot_s[i] = eligible[rr_ptr + PTR_W'(i)];
        end
        for (int i = 0; i < FIFO_UNITS; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                enc_s   = INDEX'(i);
            end else begin
                found_s = found_s;
            end
        end
        gnt_valid = found_s;
        gnt_idx   = enc_s + rr_ptr;
        if (found_s) begin
            gnt_onehot = {{(FIFO_UNITS-1){1'b0}}, 1'b1} << gnt_idx;
        end else begin
            gnt_onehot = {FIFO_UNITS{1'b0}};
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter draining four input FIFOs into destination FIFOs; pops are
// combinational, the forwarded word/push appear registered one cycle later.
module arbitro_rr
    import arbitro_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic [FIFO_UNITS-1:0] afull_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic                  push,
    output logic [INDEX-1:0]      dest,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [INDEX-1:0]      grant_idx
);

    logic [DATA_WIDTH-1:0] data_arr_s [FIFO_UNITS];
    logic [FIFO_UNITS-1:0] empty_s;
    logic [FIFO_UNITS-1:0] elig_s;
    logic [FIFO_UNITS-1:0] gnt_onehot_s;
    logic [INDEX-1:0]      gnt_idx_s;
    logic                  gnt_valid_s;

    logic                  push_q,  push_d;
    logic [INDEX-1:0]      dest_q,  dest_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [INDEX-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]      ptr_q,   ptr_d;

    assign data_arr_s[0] = data_in_0;
    assign data_arr_s[1] = data_in_1;
    assign data_arr_s[2] = data_in_2;
    assign data_arr_s[3] = data_in_3;
    assign empty_s       = {empty_3, empty_2, empty_1, empty_0};

    // A FIFO competes only if its head can be accepted; reset kills pops the same cycle.
    always_comb begin
        elig_s = {FIFO_UNITS{1'b0}};
        for (int k = 0; k < FIFO_UNITS; k++) begin
            elig_s[k] = active & ~reset & ~empty_s[k] & ~afull_out[dest_of(data_arr_s[k])];
        end
    end

    arbitro_rr_sel u_sel (
        .eligible   (elig_s),
        .rr_ptr     (ptr_q),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .gnt_valid  (gnt_valid_s)
    );

    assign pop_0 = gnt_onehot_s[0];
    assign pop_1 = gnt_onehot_s[1];
    assign pop_2 = gnt_onehot_s[2];
    assign pop_3 = gnt_onehot_s[3];

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        push_d  = gnt_valid_s;
        dest_d  = dest_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (gnt_valid_s) begin
            data_d  = data_arr_s[gnt_idx_s];
            dest_d  = dest_of(data_arr_s[gnt_idx_s]);
            grant_d = gnt_idx_s;
            ptr_d   = gnt_idx_s + PTR_W'(1);
        end else begin
            ptr_d   = ptr_q;
        end
    end

    // Output and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q  <= 1'b0;
            dest_q  <= {INDEX{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            grant_q <= {INDEX{1'b0}};
            ptr_q   <= {PTR_W{1'b0}};
        end else begin
            push_q  <= push_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign push      = push_q;
    assign dest      = dest_q;
    assign data_out  = data_q;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: hand-computed pops and registered outputs per step.
module tb_arbitro_rr;

    logic       clk;
    logic       reset;
    logic       active;
    logic       empty_0, empty_1, empty_2, empty_3;
    logic [5:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic [3:0] afull_out;
    logic       pop_0, pop_1, pop_2, pop_3;
    logic       push;
    logic [1:0] dest;
    logic [5:0] data_out;
    logic [1:0] grant_idx;

    int checks = 0;
    int errors = 0;
    int pop_cnt;

    arbitro_rr dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .empty_0   (empty_0),
        .empty_1   (empty_1),
        .empty_2   (empty_2),
        .empty_3   (empty_3),
        .data_in_0 (data_in_0),
        .data_in_1 (data_in_1),
        .data_in_2 (data_in_2),
        .data_in_3 (data_in_3),
        .afull_out (afull_out),
        .pop_0     (pop_0),
        .pop_1     (pop_1),
        .pop_2     (pop_2),
        .pop_3     (pop_3),
        .push      (push),
        .dest      (dest),
        .data_out  (data_out),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pops();
        return {4'b0000, pop_3, pop_2, pop_1, pop_0};
    endfunction

    task automatic set_empty(input logic [3:0] e);
        {empty_3, empty_2, empty_1, empty_0} = e;
    endtask

    initial begin
        reset = 1'b1; active = 1'b1; afull_out = 4'b0000;
        set_empty(4'b0000);
        data_in_0 = 6'h00; data_in_1 = 6'h01; data_in_2 = 6'h02; data_in_3 = 6'h03;

        // 1: reset with all FIFOs non-empty
        #1;
        check("rst_pop_a", pops(), 8'h00);
        tick();
        check("rst_pop_b", pops(), 8'h00);
        check("rst_push", {7'd0, push}, 8'h00);
        check("rst_grant", {6'd0, grant_idx}, 8'h00);
        check("rst_dest", {6'd0, dest}, 8'h00);
        check("rst_data", {2'd0, data_out}, 8'h00);

        // 2: only FIFO 2 non-empty, head dest 1
        reset = 1'b0;
        set_empty(4'b1011);
        data_in_2 = 6'b01_0101;
        #1;
        check("f2_pop", pops(), 8'h04);
        tick();
        check("f2_push", {7'd0, push}, 8'h01);
        check("f2_dest", {6'd0, dest}, 8'h01);
        check("f2_data", {2'd0, data_out}, 8'h15);
        check("f2_grant", {6'd0, grant_idx}, 8'h02);
        set_empty(4'b1111);
        #1;
        check("empty_pop", pops(), 8'h00);
        tick();
        check("empty_push", {7'd0, push}, 8'h00);
        check("empty_hold_data", {2'd0, data_out}, 8'h15);
        check("empty_hold_grant", {6'd0, grant_idx}, 8'h02);

        // 3: pointer back to 0, all four non-empty for 8 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_empty(4'b0000);
        data_in_0 = 6'h00; data_in_1 = 6'h01; data_in_2 = 6'h02; data_in_3 = 6'h03;
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_pop", pops(), 8'h01 << (i % 4));
            pop_cnt += int'(pop_0) + int'(pop_1) + int'(pop_2) + int'(pop_3);
            tick();
            check("rr_grant", {6'd0, grant_idx}, 8'(i % 4));
            check("rr_data", {2'd0, data_out}, 8'(i % 4));
            check("rr_push", {7'd0, push}, 8'h01);
        end
        check("rr_count", 8'(pop_cnt), 8'd8);

        // 4: FIFO0 head to almost-full destination 3 is skipped, FIFO1 served
        set_empty(4'b1100);
        data_in_0 = 6'b11_0000;
        data_in_1 = 6'b00_0001;
        afull_out = 4'b1000;
        #1;
        check("afull_skip", pops(), 8'h02);
        tick();
        check("afull_grant", {6'd0, grant_idx}, 8'h01);
        afull_out = 4'b0000;
        #1;
        check("afull_wrap_pop", pops(), 8'h01);
        tick();
        check("afull_wrap_grant", {6'd0, grant_idx}, 8'h00);
        check("afull_wrap_dest", {6'd0, dest}, 8'h03);
        check("afull_wrap_data", {2'd0, data_out}, 8'h30);
        check("afull_wrap_push", {7'd0, push}, 8'h01);

        // 5: active low for 3 cycles
        active = 1'b0;
        set_empty(4'b0000);
        data_in_0 = 6'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("inactive_pop", pops(), 8'h00);
            tick();
            check("inactive_push", {7'd0, push}, 8'h00);
            check("inactive_hold", {2'd0, data_out}, 8'h30);
        end

        // 6: reset one cycle after a grant (pointer is 1 here)
        active = 1'b1;
        #1;
        check("pre_rst_pop", pops(), 8'h02);
        tick();
        check("pre_rst_push", {7'd0, push}, 8'h01);
        reset = 1'b1;
        #1;
        check("mid_rst_pop", pops(), 8'h00);
        tick();
        check("mid_rst_push", {7'd0, push}, 8'h00);
        check("mid_rst_grant", {6'd0, grant_idx}, 8'h00);
        check("mid_rst_data", {2'd0, data_out}, 8'h00);
        reset = 1'b0;
        #1;
        check("post_rst_pop", pops(), 8'h01);
        tick();
        check("post_rst_push", {7'd0, push}, 8'h01);
        check("post_rst_grant", {6'd0, grant_idx}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
